// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the shared-ALU arbiter slice.
//   - op-select encodings OP_ADD .. OP_EQ (4 bits)
//   - default operand width
//   - divide-by-zero result/carry
//   - arbiter state type
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;
    localparam logic       DIV0_CARRY  = 1'b1;

    // StIdle: no response held; StHold: response register valid.
    typedef enum logic {StIdle, StHold} arb_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU.
// Ports:
//   a, b    in  WIDTH  operands
//   sel     in  4      op select (see alu_pkg)
//   result  out WIDTH  op result
//   carry   out 1      carry / borrow / flag bit
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (sel)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                carry  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b == '0) begin
                    result = WIDTH'(DIV0_RESULT);
                    carry  = DIV0_CARRY;
                end else begin
                    result = a / b;
                end
            end
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            OP_ROL: begin
                result = {a[WIDTH-2:0], a[WIDTH-1]};
                carry  = a[WIDTH-1];
            end
            OP_ROR: begin
                result = {a[0], a[WIDTH-1:1]};
                carry  = a[0];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one alu_core.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (at most one ready bit high)
//   req_a/req_b/req_sel packed per-requester operands/op (requester 0 in low slice)
//   rsp_valid/rsp_ready registered response handshake
//   rsp_id/rsp_result/rsp_carry  response payload
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_carry
);

    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [3:0]       alu_sel;
    logic             alu_carry;

    // Favour prio only under contention; otherwise serve whoever is asking.
    always_comb begin
        if (req_valid[0] && req_valid[1]) begin
            grant = prio_q;
        end else begin
            grant = req_valid[1];
        end
    end

    // Slot is free when nothing is held or the held result drains this cycle.
    assign accept = req_valid[grant] && (state_q == StIdle || rsp_ready) && !rst;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = accept;
    end

    assign alu_a   = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign alu_b   = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign alu_sel = grant ? req_sel[7:4] : req_sel[3:0];

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (alu_a),
        .b      (alu_b),
        .sel    (alu_sel),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept && grant == prio_q) begin
            prio_d = ~prio_q;
        end
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!accept && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (accept) begin
                rsp_id_q     <= grant;
                rsp_result_q <= alu_result;
                rsp_carry_q  <= alu_carry;
            end
        end
    end

    assign rsp_valid  = (state_q == StHold);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;

endmodule
